onehot_stable_encoder: RTL and testbench
========================================

# onehot_stable_encoder

- Parametrised, registered successor to the combinational one-hot address encoder.
- Samples an N-bit one-hot request vector from the keypad/selection matrix and filters it for stability. Maps the set bit to a rotated binary index and publishes it with a valid level and a one-cycle strobe.
- Detects invalid (zero-after-hold, multi-hot) patterns.
- Sits between the input matrix and the game/memory control FSM, which consumes `addr_strobe`.

## Interface
Parameters:
- `N_IN`, 15: width of one-hot input; N_IN ≥ 2.
- `ZERO_BIT`, N_IN-1: input bit that encodes address 0. Bit i encodes (i − ZERO_BIT) mod N_IN.
- `MODE`, 0: 0 = strict (multi-hot is an error); 1 = priority (lowest set bit index wins, never an error).
- `STABLE_CYC`, 4: consecutive identical samples required before commit; ≥ 1.
- `ADDR_W`, $clog2(N_IN): output width (derived, not overridden).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: sample enable. Low freezes sampler, counter and FSM; outputs hold, strobes forced 0.
- `addr_in` in N_IN: raw one-hot request.
- `addr_out` out ADDR_W: last committed valid address; holds through release.
- `addr_valid` out 1: level, high while FSM is in HELD.
- `addr_strobe` out 1: one-cycle pulse on entry to HELD.
- `err_strobe` out 1: one-cycle pulse on entry to FAULT.

## Operation
- Input register `in_q` captures `addr_in` each enabled edge.
- Candidate logic:
  - compares `in_q` with candidate register `cand_q`;
  - on mismatch, loads `cand_q` and sets the run counter to 1;
  - on match, increments the counter, saturating at STABLE_CYC.
- Commit occurs when the counter reaches STABLE_CYC and the classification of `cand_q` differs from the currently committed pattern.
- Classification of `cand_q`:
  - ZERO = no bit set;
  - VALID = exactly one bit set, or ≥1 bit set in MODE 1;
  - INVALID = ≥2 bits set in MODE 0.
- FSM states IDLE, HELD, FAULT; transitions happen only on commit:
  - any state → IDLE on ZERO commit;
  - IDLE/FAULT → HELD on VALID commit. Load `addr_out`, pulse `addr_strobe`.
  - HELD → HELD on VALID commit of a different bit. Reload `addr_out`, pulse `addr_strobe`.
  - any state → FAULT on INVALID commit. Pulse `err_strobe`; `addr_out` holds.
- The same bit re-pressed after release (HELD → IDLE → HELD) strobes again. The same bit held continuously never re-strobes.
- Mapping: `addr_out` = (i − ZERO_BIT) mod N_IN, computed in ADDR_W+1 bits before wrap. No out-of-range value is ever produced.

## Timing
- Reset values: `addr_out`=0, `addr_valid`=0, `addr_strobe`=0, `err_strobe`=0; FSM IDLE; `in_q`, `cand_q`, counter = 0.
- Latency: new stable value first sampled at edge E0. `addr_out`, `addr_valid`, `addr_strobe` and `err_strobe` update at edge E0+STABLE_CYC. With STABLE_CYC=1 this is a one-edge pipeline.
- Any change of `addr_in` before commit restarts the count from the new value. Glitches shorter than STABLE_CYC samples produce no output change.
- `en` low mid-count: counter frozen, not cleared; counting resumes when `en` returns high.
- `rst` asserted mid-count or mid-strobe: all state clears on that edge and the pending commit is discarded. `rst` has priority over `en`.
- `addr_strobe` and `err_strobe` are never high in the same cycle and are never high for more than one consecutive cycle.

## Structure
- Shared package `encoder_pkg` holds:
  - FSM state enum (IDLE, HELD, FAULT);
  - classification enum (ZERO, VALID, INVALID);
  - the rotated-index mapping function, so other encoders reuse it.
- One sub-module `onehot_index_map`: purely combinational. Takes N_IN, ZERO_BIT and MODE; outputs index plus class. Instantiated once on `cand_q`.

## Test plan
- Defaults. Reset, then hold `addr_in`=15'h4000 for 6 cycles. Expect:
  - `addr_out`=0, `addr_valid`=1;
  - `addr_strobe` exactly once, at edge E0+4.
- `addr_in`=15'h0001 held, then switched to 15'h2000 held (no release). Expect:
  - `addr_out` 1 then 14;
  - two strobes 4 edges after each change.
- Glitch: 15'h0004 for 3 cycles, then 0. Expect no strobe and `addr_valid` stays 0.
- MODE 0, `addr_in`=15'h0003 held. Expect one `err_strobe`, `addr_valid`=0, `addr_out` unchanged. MODE 1, same input: `addr_out`=1 with strobe.
- Re-press: 15'h0010 held, then 0 for 5 cycles, then 15'h0010 again. Expect:
  - `addr_out`=5;
  - two strobes;
  - `addr_valid` low only during the IDLE interval.
- Reset during count (input stable for 2 cycles, then `rst`). Expect all outputs 0 and no strobe. With `en` low for 3 cycles mid-count, the strobe is delayed by exactly 3 cycles.

Source files
------------

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared types and rotated-index mapping for one-hot encoders
package encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HELD  = 2'd1,
    ST_FAULT = 2'd2
  } enc_state_t;

  typedef enum logic [1:0] {
    CLS_ZERO    = 2'd0,
    CLS_VALID   = 2'd1,
    CLS_INVALID = 2'd2
  } enc_class_t;

  localparam int MODE_STRICT = 0;

  // Bit position -> address, (bit_idx - zero_bit) mod n without going negative.
  function automatic int rot_index(input int bit_idx, input int zero_bit, input int n);
    int sum;
    sum = bit_idx + n - zero_bit;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/onehot_index_map.sv
// rtl/onehot_index_map.sv - combinational classifier and rotated index of a one-hot vector
module onehot_index_map
  import encoder_pkg::*;
#(
  parameter int N_IN     = 15,
  parameter int ZERO_BIT = N_IN - 1,
  parameter int MODE     = 0,
  parameter int ADDR_W   = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]   vec,
  output logic [ADDR_W-1:0] idx,
  output enc_class_t        cls
);

  logic any_set;
  logic multi_set;

  always_comb begin
    idx       = '0;
    cls       = CLS_VALID;
    any_set   = 1'b0;
    multi_set = 1'b0;
    // Scan high to low so the lowest set bit leaves the final index.
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (vec[i]) begin
        multi_set = multi_set | any_set;
        any_set   = 1'b1;
        idx       = ADDR_W'(rot_index(i, ZERO_BIT, N_IN));
      end
    end
    if (!any_set) begin
      cls = CLS_ZERO;
    end else if (multi_set && MODE == MODE_STRICT) begin
      cls = CLS_INVALID;
    end
  end

endmodule

// File: rtl/onehot_stable_encoder.sv
// rtl/onehot_stable_encoder.sv - stability-filtered registered one-hot to rotated binary encoder
module onehot_stable_encoder
  import encoder_pkg::*;
#(
  parameter int N_IN       = 15,
  parameter int ZERO_BIT   = N_IN - 1,
  parameter int MODE       = 0,
  parameter int STABLE_CYC = 4,
  localparam int ADDR_W    = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_IN-1:0]   addr_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              addr_strobe,
  output logic              err_strobe
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  logic [N_IN-1:0]   in_q, cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] map_idx, addr_d;
  enc_class_t        map_cls;
  logic              differs, commit, astb_d, estb_d;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (in_q != cand_q) begin
      cand_d = in_q;
      cnt_d  = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Classify the candidate as it will be after this edge, so the commit
  // lands on the same edge the run count saturates.
  onehot_index_map #(
    .N_IN    (N_IN),
    .ZERO_BIT(ZERO_BIT),
    .MODE    (MODE),
    .ADDR_W  (ADDR_W)
  ) u_map (
    .vec(cand_d),
    .idx(map_idx),
    .cls(map_cls)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_out;
    astb_d  = 1'b0;
    estb_d  = 1'b0;
    differs = 1'b1;
    case (state_q)
      ST_IDLE:  differs = (map_cls != CLS_ZERO);
      ST_HELD:  differs = (map_cls != CLS_VALID) || (map_idx != addr_out);
      ST_FAULT: differs = (map_cls != CLS_INVALID);
      default:  differs = 1'b1;
    endcase
    // A live strobe defers the next commit a cycle so pulses never run together.
    commit = en && (cnt_d == CNT_MAX) && differs && !(addr_strobe || err_strobe);
    if (commit) begin
      case (map_cls)
        CLS_ZERO: state_d = ST_IDLE;
        CLS_VALID: begin
          state_d = ST_HELD;
          addr_d  = map_idx;
          astb_d  = 1'b1;
        end
        CLS_INVALID: begin
          state_d = ST_FAULT;
          estb_d  = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q        <= '0;
      cand_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      addr_out    <= '0;
      addr_strobe <= 1'b0;
      err_strobe  <= 1'b0;
    end else begin
      addr_strobe <= astb_d;
      err_strobe  <= estb_d;
      if (en) begin
        in_q     <= addr_in;
        cand_q   <= cand_d;
        cnt_q    <= cnt_d;
        state_q  <= state_d;
        addr_out <= addr_d;
      end
    end
  end

  assign addr_valid = (state_q == ST_HELD);

endmodule

// File: tb/tb_onehot_stable_encoder.sv
// tb/tb_onehot_stable_encoder.sv - self-checking bench for onehot_stable_encoder, strict and priority modes
module tb_onehot_stable_encoder;

  localparam int N  = 15;
  localparam int ZB = 14;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [N-1:0]  addr_in = '0;
  logic [3:0]    aout [2];
  logic          aval [2];
  logic          astb [2];
  logic          estb [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;

  // Reference state: last sampled input, recent enabled samples, per-mode outputs.
  logic [N-1:0] m_inq = '0;
  logic [N-1:0] hist [$];
  int           m_state [2] = '{0, 0};
  int           m_addr [2]  = '{0, 0};
  bit           m_astb [2]  = '{0, 0};
  bit           m_estb [2]  = '{0, 0};

  onehot_stable_encoder #(.N_IN(N), .ZERO_BIT(ZB), .MODE(0), .STABLE_CYC(S)) dut0 (
    .clk(clk), .rst(rst), .en(en), .addr_in(addr_in),
    .addr_out(aout[0]), .addr_valid(aval[0]), .addr_strobe(astb[0]), .err_strobe(estb[0])
  );

  onehot_stable_encoder #(.N_IN(N), .ZERO_BIT(ZB), .MODE(1), .STABLE_CYC(S)) dut1 (
    .clk(clk), .rst(rst), .en(en), .addr_in(addr_in),
    .addr_out(aout[1]), .addr_valid(aval[1]), .addr_strobe(astb[1]), .err_strobe(estb[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_index(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++)
      if (v[i] && r < 0) r = ((i - ZB) % N + N) % N;
    return (r < 0) ? 0 : r;
  endfunction

  task automatic model_edge();
    bit same;
    int pc, cls, idx;
    logic [N-1:0] v;
    if (rst) begin
      m_inq = '0;
      hist.delete();
      for (int d = 0; d < 2; d++) begin
        m_state[d] = 0; m_addr[d] = 0; m_astb[d] = 0; m_estb[d] = 0;
      end
      return;
    end
    for (int d = 0; d < 2; d++) begin
      m_astb[d] = 0; m_estb[d] = 0;
    end
    if (!en) return;
    hist.push_back(m_inq);
    if (hist.size() > S) void'(hist.pop_front());
    m_inq = addr_in;
    if (hist.size() != S) return;
    same = 1'b1;
    foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
    if (!same) return;
    v   = hist[0];
    pc  = $countones(v);
    idx = ref_index(v);
    for (int d = 0; d < 2; d++) begin
      cls = (pc == 0) ? 0 : ((pc > 1 && d == 0) ? 2 : 1);
      if (cls == 0) begin
        m_state[d] = 0;
      end else if (cls == 1) begin
        if (m_state[d] != 1 || m_addr[d] != idx) begin
          m_state[d] = 1; m_addr[d] = idx; m_astb[d] = 1;
        end
      end else if (m_state[d] != 2) begin
        m_state[d] = 2; m_estb[d] = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [N-1:0] a);
    rst = r; en = e; addr_in = a;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    cmp_on = 1'b1;
  endtask

  // Hold a value for n enabled cycles, pinning the step at which each strobe fires (-1 = never).
  task automatic hold(input logic [N-1:0] a, input int n, input int at_a0, input int at_a1,
                      input int at_e0, input string tag);
    for (int k = 0; k < n; k++) begin
      step(1'b0, 1'b1, a);
      chk({tag, "_astb0"}, int'(astb[0]), int'(k == at_a0));
      chk({tag, "_astb1"}, int'(astb[1]), int'(k == at_a1));
      chk({tag, "_estb0"}, int'(estb[0]), int'(k == at_e0));
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cmp%0d_addr_out", d), int'(aout[d]), m_addr[d]);
        chk($sformatf("cmp%0d_addr_valid", d), int'(aval[d]), int'(m_state[d] == 1));
        chk($sformatf("cmp%0d_addr_strobe", d), int'(astb[d]), int'(m_astb[d]));
        chk($sformatf("cmp%0d_err_strobe", d), int'(estb[d]), int'(m_estb[d]));
      end
    end
  end

  initial begin
    logic [N-1:0] a;
    int kind, len, b1, b2;

    chk("pin_map_bit14", ref_index(15'h4000), 0);
    chk("pin_map_bit0", ref_index(15'h0001), 1);
    chk("pin_map_bit13", ref_index(15'h2000), 14);

    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("rst_addr_out", int'(aout[0]), 0);
    chk("rst_addr_valid", int'(aval[0]), 0);
    chk("rst_addr_strobe", int'(astb[0]), 0);
    chk("rst_err_strobe", int'(estb[0]), 0);

    hold(15'h4000, 6, 4, 4, -1, "bit14");
    chk("bit14_addr_out", int'(aout[0]), 0);
    chk("bit14_valid", int'(aval[0]), 1);
    chk("pin_model_addr14", m_addr[0], 0);

    hold(15'h0001, 6, 4, 4, -1, "bit0");
    chk("bit0_addr_out", int'(aout[0]), 1);
    hold(15'h2000, 6, 4, 4, -1, "bit13");
    chk("bit13_addr_out", int'(aout[0]), 14);
    chk("pin_model_addr13", m_addr[0], 14);

    hold(15'h0000, 6, -1, -1, -1, "rel1");
    chk("rel1_valid", int'(aval[0]), 0);
    hold(15'h0004, 3, -1, -1, -1, "glitch");
    hold(15'h0000, 6, -1, -1, -1, "glitch_end");
    chk("glitch_valid", int'(aval[0]), 0);
    chk("glitch_addr_hold", int'(aout[0]), 14);

    hold(15'h0003, 6, -1, 4, 4, "multi");
    chk("multi_strict_valid", int'(aval[0]), 0);
    chk("multi_strict_addr", int'(aout[0]), 14);
    chk("multi_prio_valid", int'(aval[1]), 1);
    chk("multi_prio_addr", int'(aout[1]), 1);
    hold(15'h0000, 6, -1, -1, -1, "rel2");

    hold(15'h0010, 6, 4, 4, -1, "press1");
    chk("press1_addr", int'(aout[0]), 5);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 15'h0000);
      chk("release_valid", int'(aval[0]), int'(k < 4));
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 15'h0010);
      chk("press2_valid", int'(aval[0]), int'(k >= 4));
      chk("press2_astb", int'(astb[0]), int'(k == 4));
    end
    chk("press2_addr", int'(aout[0]), 5);

    hold(15'h0100, 2, -1, -1, -1, "pre_rst");
    step(1'b1, 1'b1, 15'h0100);
    chk("midrst_addr_out", int'(aout[0]), 0);
    chk("midrst_valid", int'(aval[0]), 0);
    chk("midrst_astb", int'(astb[0]), 0);
    hold(15'h0100, 6, 4, 4, -1, "post_rst");
    chk("post_rst_addr", int'(aout[0]), 9);

    hold(15'h0040, 2, -1, -1, -1, "en_pre");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 15'h0040);
      chk("en_low_astb", int'(astb[0]), 0);
    end
    hold(15'h0040, 4, 2, 2, -1, "en_post");
    chk("en_post_addr", int'(aout[0]), 7);

    while (cyc < 3000) begin
      kind = $urandom_range(0, 9);
      b1 = $urandom_range(0, N - 1);
      b2 = (b1 + $urandom_range(1, N - 1)) % N;
      if (kind < 2) a = '0;
      else if (kind < 7) a = N'(1) << b1;
      else if (kind < 9) a = (N'(1) << b1) | (N'(1) << b2);
      else a = N'($urandom);
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++)
        step(bit'($urandom_range(0, 199) == 0), bit'($urandom_range(0, 9) != 0), a);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
